// File: rtl/box_mover.sv
// Bouncing rectangle position generator, advanced once per frame on vys.
// Optional key pause path (sync + debounce + toggle) enabled by KEY_PAUSE_EN.
module box_mover #(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int BOX_W   = 150,
  parameter int BOX_H   = 100,
  parameter int STEP    = 2,
  parameter int DEB_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vys,
  input  logic       key_in,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       frame_tick,
  output logic       paused
);

  localparam logic [10:0] X_MAX  = 11'(H_ACT - BOX_W);
  localparam logic [10:0] Y_MAX  = 11'(V_ACT - BOX_H);
  localparam logic [10:0] X_INIT = 11'((H_ACT - BOX_W) / 2);
  localparam logic [10:0] Y_INIT = 11'((V_ACT - BOX_H) / 2);
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic        vys_r;
  logic        dx;
  logic        dy;
  logic [10:0] nx;
  logic [10:0] ny;

  // Returns {next_dir, next_pos}; clamps to the limit and flips direction.
  function automatic logic [10:0] step_axis(
    input logic [10:0] pos,
    input logic        dir,
    input logic [10:0] lim
  );
    logic [10:0] p;
    logic        d;
    p = pos;
    d = dir;
    if (dir) begin
      if (pos + STEP_W >= lim) begin
        p = lim;
        d = 1'b0;
      end else begin
        p = pos + STEP_W;
      end
    end else begin
      if (pos <= STEP_W) begin
        p = 11'd0;
        d = 1'b1;
      end else begin
        p = pos - STEP_W;
      end
    end
    return {d, p[9:0]};
  endfunction

  always_comb begin
    nx = step_axis({1'b0, box_x}, dx, X_MAX);
    ny = step_axis({1'b0, box_y}, dy, Y_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vys_r      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vys_r      <= vys;
      frame_tick <= vys & ~vys_r;
    end
  end

  // paused here is the pre-toggle value when a key toggle lands this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_x <= X_INIT[9:0];
      box_y <= Y_INIT[9:0];
      dx    <= 1'b1;
      dy    <= 1'b1;
    end else if (frame_tick && !paused) begin
      box_x <= nx[9:0];
      dx    <= nx[10];
      box_y <= ny[9:0];
      dy    <= ny[10];
    end
  end

`ifdef KEY_PAUSE_EN
  localparam int CW = $clog2(DEB_CNT + 1);

  logic [1:0]    key_sync;
  logic          key_lvl;
  logic [CW-1:0] deb_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sync <= 2'b11;
      key_lvl  <= 1'b1;
      deb_cnt  <= '0;
      paused   <= 1'b0;
    end else begin
      key_sync <= {key_sync[0], key_in};
      if (key_sync[1] == key_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CW'(DEB_CNT - 1)) begin
        deb_cnt <= '0;
        key_lvl <= key_sync[1];
        if (!key_sync[1]) begin
          paused <= ~paused;
        end
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_key;
  assign unused_key = ^{key_in, DEB_CNT[0]};
  assign paused     = 1'b0;
`endif

endmodule

// File: tb/tb_box_mover.sv
// Directed bench for box_mover: reset, motion, bounces, pause, async reset.
// Pause scenarios are exercised when built with KEY_PAUSE_EN.
module tb_box_mover;

  logic       clk;
  logic       rst;
  logic       vys;
  logic       key_in;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       frame_tick;
  logic       paused;

  int n_tests;
  int n_fail;
  int ticks;

  box_mover #(
    .DEB_CNT(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vys       (vys),
    .key_in    (key_in),
    .box_x     (box_x),
    .box_y     (box_y),
    .frame_tick(frame_tick),
    .paused    (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_tick === 1'b1) ticks++;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    vys = 1'b1;
    cycles(2);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vys = 1'b0;
      cycles(2);
      vys = 1'b1;
      cycles(3);
    end
  endtask

  task automatic chk_pos(input string nm, input int ex, input int ey);
    n_tests++;
    if (box_x !== 10'(ex) || box_y !== 10'(ey)) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d, expected x=%0d y=%0d",
               nm, box_x, box_y, ex, ey);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_pos("reset_hold", 245, 190);
    n_tests++;
    if (frame_tick !== 1'b0 || paused !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got tick=%b paused=%b, expected 0 0",
               frame_tick, paused);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_pos("reset_release", 245, 190);
    n_tests++;
    if (frame_tick !== 1'b0 || paused !== 1'b0) begin
      n_fail++;
      $display("FAIL release_flags: got tick=%b paused=%b, expected 0 0",
               frame_tick, paused);
    end
  endtask

  task automatic test_three_frames();
    int t0;
    do_reset();
    t0 = ticks;
    frames(3);
    n_tests++;
    if (ticks - t0 !== 3) begin
      n_fail++;
      $display("FAIL three_ticks: got %0d tick cycles, expected 3", ticks - t0);
    end
    chk_pos("three_frames", 251, 196);
  endtask

  task automatic test_vertical_bounce();
    do_reset();
    frames(95);
    chk_pos("v_bounce_95", 435, 380);
    frames(1);
    chk_pos("v_bounce_96", 437, 378);
  endtask

  task automatic test_horizontal_bounce();
    do_reset();
    frames(123);
    chk_pos("h_bounce_123", 490, 324);
    frames(1);
    chk_pos("h_bounce_124", 488, 322);
  endtask

`ifdef KEY_PAUSE_EN
  task automatic test_pause();
    int t0;
    do_reset();
    key_in = 1'b0;
    cycles(20);
    key_in = 1'b1;
    cycles(4);
    n_tests++;
    if (paused !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_press: got paused=%b, expected 1", paused);
    end
    t0 = ticks;
    frames(5);
    chk_pos("pause_hold", 245, 190);
    n_tests++;
    if (ticks - t0 !== 5) begin
      n_fail++;
      $display("FAIL pause_ticks: got %0d, expected 5", ticks - t0);
    end
    cycles(40);
    n_tests++;
    if (paused !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_release: got paused=%b, expected 1", paused);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    key_in = 1'b0;
    cycles(10);
    key_in = 1'b1;
    cycles(30);
    n_tests++;
    if (paused !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch: got paused=%b, expected 0", paused);
    end
    frames(1);
    chk_pos("glitch_move", 247, 192);
  endtask
`else
  task automatic test_no_pause();
    do_reset();
    key_in = 1'b0;
    cycles(40);
    frames(3);
    key_in = 1'b1;
    n_tests++;
    if (paused !== 1'b0) begin
      n_fail++;
      $display("FAIL no_pause: got paused=%b, expected 0", paused);
    end
    chk_pos("no_pause_move", 251, 196);
  endtask
`endif

  task automatic test_reset_mid_frame();
    int t0;
    do_reset();
    frames(10);
    chk_pos("pre_reset_10", 265, 210);
    vys = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_pos("async_reset", 245, 190);
    @(negedge clk);
    vys = 1'b1;
    rst = 1'b1;
    t0 = ticks;
    cycles(4);
    n_tests++;
    if (ticks !== t0) begin
      n_fail++;
      $display("FAIL residual_tick: got %0d ticks, expected 0", ticks - t0);
    end
    chk_pos("post_reset_idle", 245, 190);
    frames(1);
    chk_pos("post_reset_move", 247, 192);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ticks   = 0;
    rst     = 1'b1;
    vys     = 1'b1;
    key_in  = 1'b1;
    test_reset();
    test_three_frames();
    test_vertical_bounce();
    test_horizontal_bounce();
`ifdef KEY_PAUSE_EN
    test_pause();
    test_glitch();
`else
    test_no_pause();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/box_mover.md
BOX_MOVER -- requirements
Module: box_mover

Interface
REQ-001 Parameter H_ACT, 640, active-area width in pixels.
REQ-002 Parameter V_ACT, 480, active-area height in lines.
REQ-003 Parameter BOX_W, 150, rectangle width in pixels.
REQ-004 Parameter BOX_H, 100, rectangle height in lines.
REQ-005 Parameter STEP, 2, pixels moved per axis per frame; legal range is 1 <= STEP < min(H_ACT-BOX_W, V_ACT-BOX_H).
REQ-006 Parameter DEB_CNT, 500000, key-stable cycles required before a level is accepted (20 ms at 25 MHz).
REQ-007 clk  input  1  pixel clock; the only clock in the block.
REQ-008 rst  input  1  reset; asynchronous, active-low.
REQ-009 vys  input  1  vertical sync from the timing generator; low pulse at frame start, asynchronous-safe not required (same clk domain).
REQ-010 key_in  input  1  pause push-button, active-low, asynchronous to clk.
REQ-011 box_x  output  10  registered rectangle left edge, active-area coordinates.
REQ-012 box_y  output  10  registered rectangle top edge, active-area coordinates.
REQ-013 frame_tick  output  1  one-cycle registered pulse per frame.
REQ-014 paused  output  1  registered pause state; 1 = movement frozen.

Function
REQ-015 The block SHALL register vys every cycle into vys_r and SHALL drive frame_tick high for exactly one cycle, in the cycle after the edge at which vys is sampled 1 while vys_r is 0.
REQ-016 Position and direction registers SHALL update only in a cycle where frame_tick is 1 and paused is 0, with the new value visible on the following cycle.
REQ-017 Horizontal moving right (dx=1): if box_x+STEP >= H_ACT-BOX_W then box_x <= H_ACT-BOX_W and dx <= 0, else box_x <= box_x+STEP.
REQ-018 Horizontal moving left (dx=0): if box_x <= STEP then box_x <= 0 and dx <= 1, else box_x <= box_x-STEP.
REQ-019 Vertical axis SHALL follow REQ-017/018 with box_y, dy, V_ACT and BOX_H; both axes SHALL bounce independently and simultaneously when both limits are reached in the same frame.
REQ-020 box_x SHALL never exceed H_ACT-BOX_W and box_y SHALL never exceed V_ACT-BOX_H; all arithmetic SHALL be 11-bit internally, with no wrap.
REQ-021 While paused=1, box_x, box_y, dx and dy SHALL hold, and frame_tick SHALL keep pulsing.
REQ-022 If a pause toggle and frame_tick occur in the same cycle, the position update SHALL use the pre-toggle paused value.

Reset
REQ-023 While rst=0, outputs SHALL be forced immediately: box_x=(H_ACT-BOX_W)/2 (245), box_y=(V_ACT-BOX_H)/2 (190), frame_tick=0, paused=0.
REQ-024 While rst=0, internal state SHALL be forced immediately: dx=1, dy=1, vys_r=1, debounce state cleared, accepted key level=1.
REQ-025 Reset asserted mid-frame or mid-debounce SHALL abandon all in-progress activity with no residual pulse after release.

Configuration
REQ-026 Macro KEY_PAUSE_EN defined: key_in SHALL pass through a 2-flop synchronizer.
REQ-027 Macro KEY_PAUSE_EN defined: a debounce counter SHALL accept a new level only after DEB_CNT consecutive cycles at that level.
REQ-028 Macro KEY_PAUSE_EN defined: each accepted 1->0 transition SHALL toggle paused once; releases SHALL have no effect.
REQ-029 Macro KEY_PAUSE_EN undefined: key_in SHALL be ignored, paused SHALL be constant 0, and no synchronizer or debounce logic SHALL be synthesized.

Verification
REQ-030 Release rst -> box_x=245, box_y=190, paused=0, frame_tick=0 on the first cycle.
REQ-031 Three vys low->high transitions -> exactly three one-cycle frame_tick pulses; box_x=251, box_y=196.
REQ-032 95 frames -> box_y=380 and dy=0; frame 96 -> box_y=378.
REQ-033 123 frames -> box_x clamps to 490; frame 124 -> box_x=488.
REQ-034 KEY_PAUSE_EN, DEB_CNT=16: key_in low 20 cycles -> paused=1; five frames -> position unchanged.
REQ-035 KEY_PAUSE_EN, DEB_CNT=16: 10-cycle low glitch -> no toggle.
REQ-036 KEY_PAUSE_EN undefined -> paused stays 0 while position advances.
REQ-037 rst pulsed low mid-frame after 10 frames -> outputs return to 245/190 asynchronously, and the next frame resumes moving right/down.
